// File: rtl/csa_sum_sequencer.sv
// Frame accumulator: folds up to five buffered operands per pass into a running sum
// through one shared 6-input carry-save adder. Optional saturation: CSA_SEQ_SAT_EN.

module csa_adder_6in #(
  parameter int p_input_width = 20
) (
  input  logic [p_input_width-1:0] a,
  input  logic [p_input_width-1:0] b,
  input  logic [p_input_width-1:0] c,
  input  logic [p_input_width-1:0] d,
  input  logic [p_input_width-1:0] e,
  input  logic [p_input_width-1:0] f,
  output logic [p_input_width+2:0] sum
);
  localparam int W = p_input_width + 3;

  logic [W-1:0] xa, xb, xc, xd, xe, xf;
  logic [W-1:0] s1, c1, s2, c2, s3, c3, s4, c4;

  // Six operands are below 2^W, so carries shifted out of the top bit are always zero
  always_comb begin
    xa = W'(a);
    xb = W'(b);
    xc = W'(c);
    xd = W'(d);
    xe = W'(e);
    xf = W'(f);
    s1 = xa ^ xb ^ xc;
    c1 = ((xa & xb) | (xa & xc) | (xb & xc)) << 1;
    s2 = xd ^ xe ^ xf;
    c2 = ((xd & xe) | (xd & xf) | (xe & xf)) << 1;
    s3 = s1 ^ c1 ^ s2;
    c3 = ((s1 & c1) | (s1 & s2) | (c1 & s2)) << 1;
    s4 = s3 ^ c3 ^ c2;
    c4 = ((s3 & c3) | (s3 & c2) | (c3 & c2)) << 1;
    sum = s4 + c4;
  end
endmodule

module csa_sum_sequencer #(
  parameter int P_WIDTH     = 14,
  parameter int P_ACC_WIDTH = 20,
  parameter int P_CNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_WIDTH-1:0]     i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [P_ACC_WIDTH-1:0] o_sum,
  output logic [P_CNT_WIDTH-1:0] o_count,
  output logic                   o_ovf,
  output logic                   o_valid,
  input  logic                   i_ready
);
  typedef enum logic [1:0] {S_COLLECT, S_ADD, S_DONE} state_t;

  state_t                 state;
  logic [P_ACC_WIDTH-1:0] acc;
  logic [P_ACC_WIDTH-1:0] slot [5];
  logic [2:0]             n;
  logic                   last_flag;
  logic                   ovf;
  logic                   xfer;
  logic [P_ACC_WIDTH+2:0] add_out;
  logic                   add_ovf;
  logic [P_ACC_WIDTH-1:0] acc_next;

  assign xfer    = i_valid & o_ready;
  assign o_sum   = acc;
  assign o_ovf   = ovf;
  assign add_ovf = |add_out[P_ACC_WIDTH+2:P_ACC_WIDTH];

  csa_adder_6in #(.p_input_width(P_ACC_WIDTH)) u_adder (
    .a   (acc),
    .b   (slot[0]),
    .c   (slot[1]),
    .d   (slot[2]),
    .e   (slot[3]),
    .f   (slot[4]),
    .sum (add_out)
  );

`ifdef CSA_SEQ_SAT_EN
  assign acc_next = (ovf | add_ovf) ? '1 : add_out[P_ACC_WIDTH-1:0];
`else
  assign acc_next = add_out[P_ACC_WIDTH-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_COLLECT;
      acc       <= '0;
      for (int unsigned i = 0; i < 5; i++) slot[i] <= '0;
      n         <= '0;
      o_count   <= '0;
      last_flag <= 1'b0;
      ovf       <= 1'b0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (xfer) begin
            for (int unsigned i = 0; i < 5; i++)
              if (n == i[2:0]) slot[i] <= P_ACC_WIDTH'(i_data);
            n         <= n + 3'd1;
            o_count   <= o_count + P_CNT_WIDTH'(1);
            last_flag <= i_last;
            if (n == 3'd4 || i_last) begin
              state   <= S_ADD;
              o_ready <= 1'b0;
            end
          end
        end
        S_ADD: begin
          acc <= acc_next;
          ovf <= ovf | add_ovf;
          for (int unsigned i = 0; i < 5; i++) slot[i] <= '0;
          n <= '0;
          if (last_flag) begin
            state   <= S_DONE;
            o_valid <= 1'b1;
          end else begin
            state   <= S_COLLECT;
            o_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state     <= S_COLLECT;
            acc       <= '0;
            o_count   <= '0;
            ovf       <= 1'b0;
            last_flag <= 1'b0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
          end
        end
        default: begin
          state   <= S_COLLECT;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_sum_sequencer.sv
// Randomized bench for csa_sum_sequencer: per-cycle frame-level model plus directed literal checks.

module tb_csa_sum_sequencer;
  localparam int W  = 14;
  localparam int AW = 20;
  localparam int CW = 8;
  localparam longint MAXV = (64'd1 << AW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic [AW-1:0] o_sum;
  logic [CW-1:0] o_count;
  logic          o_ovf;
  logic          o_valid;
  logic          i_ready = 1'b0;

  csa_sum_sequencer #(.P_WIDTH(W), .P_ACC_WIDTH(AW), .P_CNT_WIDTH(CW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_sum   (o_sum),
    .o_count (o_count),
    .o_ovf   (o_ovf),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  bit rnd_ready = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_sum(input longint t);
`ifdef CSA_SEQ_SAT_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (64'd1 << AW);
`endif
  endfunction

  // Frame-level reference: exact integer total, operand count, and handshake timing
  bit     m_live = 1'b0;
  bit     m_ready, m_valid, m_adding, m_last;
  int     m_grp, m_cnt;
  longint m_total;

  always @(negedge i_clk) begin
    if (m_live) begin
      check("ready", o_ready, m_ready);
      check("valid", o_valid, m_valid);
      if (m_valid) begin
        check("sum", o_sum, exp_sum(m_total));
        check("count", o_count, m_cnt % 256);
        check("ovf", o_ovf, m_total > MAXV);
      end
    end
    if (i_rst) begin
      m_live = 1'b1; m_ready = 1'b1; m_valid = 1'b0; m_adding = 1'b0; m_last = 1'b0;
      m_grp = 0; m_cnt = 0; m_total = 0;
    end else if (m_live) begin
      if (m_valid) begin
        if (i_ready) begin
          m_valid = 1'b0; m_ready = 1'b1; m_total = 0; m_cnt = 0;
        end
      end else if (m_adding) begin
        m_adding = 1'b0; m_grp = 0;
        if (m_last) m_valid = 1'b1;
        else        m_ready = 1'b1;
      end else if (i_valid && m_ready) begin
        m_total += longint'(i_data);
        m_cnt++;
        m_grp++;
        if (m_grp == 5 || i_last) begin
          m_ready = 1'b0; m_adding = 1'b1; m_last = i_last;
        end
      end
    end
  end

  task automatic put(input logic [W-1:0] d, input logic l);
    int k = 0;
    i_data = d; i_last = l; i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && k < 300) begin
      @(posedge i_clk); #1;
      if (rnd_ready) i_ready = 1'($urandom_range(1, 0));
      @(negedge i_clk);
      k++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL put_timeout: got o_ready %0d expected 1", o_ready);
    end
    xfer_cyc = cyc;
    @(posedge i_clk); #1;
    if (rnd_ready) i_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic frame_const(input int n, input logic [W-1:0] v);
    for (int i = 0; i < n; i++) put(v, i == n - 1);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic get_result(input int hold, input bit tie, output logic [AW-1:0] rs,
                            output logic [CW-1:0] rc, output logic ro, output int lat);
    int k = 0;
    @(negedge i_clk);
    while (!o_valid && k < 300) begin @(negedge i_clk); k++; end
    if (!o_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: got o_valid %0d expected 1", o_valid);
    end
    rs = o_sum; rc = o_count; ro = o_ovf; lat = cyc - xfer_cyc;
    if (!tie) begin
      repeat (hold) @(posedge i_clk);
      #1 i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
    end
  endtask

  logic [AW-1:0] rs;
  logic [CW-1:0] rc;
  logic          ro;
  int            lat;

  initial begin
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // 1: small frame, latency
    put(14'd1, 1'b0); put(14'd2, 1'b0); put(14'd3, 1'b1);
    i_valid = 1'b0; i_last = 1'b0;
    get_result(1, 1'b0, rs, rc, ro, lat);
    check("t1_sum", rs, 6); check("t1_count", rc, 3); check("t1_ovf", ro, 0);
    check("t1_latency", lat, 2);

    // 2: back-to-back 12 x 100
    frame_const(12, 14'd100);
    get_result(1, 1'b0, rs, rc, ro, lat);
    check("t2_sum", rs, 1200); check("t2_count", rc, 12);

    // 3: long hold in done, then a one-operand frame
    frame_const(2, 14'd3);
    get_result(5, 1'b0, rs, rc, ro, lat);
    check("t3_sum", rs, 6);
    frame_const(1, 14'd7);
    get_result(1, 1'b0, rs, rc, ro, lat);
    check("t3_next_sum", rs, 7);

    // 4: overflow
    frame_const(80, 14'd16383);
    get_result(1, 1'b0, rs, rc, ro, lat);
`ifdef CSA_SEQ_SAT_EN
    check("t4_sum", rs, 1048575);
`else
    check("t4_sum", rs, 262064);
`endif
    check("t4_ovf", ro, 1); check("t4_count", rc, 80);

    // 5: reset mid-frame
    for (int i = 0; i < 4; i++) put(14'd50, 1'b0);
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("t5_ready", o_ready, 1); check("t5_valid", o_valid, 0);
    @(posedge i_clk); #1;
    frame_const(1, 14'd9);
    get_result(1, 1'b0, rs, rc, ro, lat);
    check("t5_sum", rs, 9); check("t5_count", rc, 1);

    // 6: single max operand, downstream always ready
    i_ready = 1'b1;
    frame_const(1, 14'd16383);
    get_result(0, 1'b1, rs, rc, ro, lat);
    check("t6_sum", rs, 16383); check("t6_count", rc, 1);
    @(negedge i_clk);
    check("t6_pulse", o_valid, 0); check("t6_ready_back", o_ready, 1);
    @(posedge i_clk); #1 i_ready = 1'b0;

    // 7: operand counter wrap
    frame_const(260, 14'd1);
    get_result(1, 1'b0, rs, rc, ro, lat);
    check("t7_count", rc, 4); check("t7_sum", rs, 260);

    // random frames with random gaps and downstream stalls
    rnd_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(90, 1);
      int mode = $urandom_range(2, 0);
      for (int i = 0; i < len; i++) begin
        logic [W-1:0] d;
        case (mode)
          0:       d = W'($urandom_range(255, 0));
          1:       d = W'($urandom);
          default: d = W'($urandom_range(16383, 16000));
        endcase
        put(d, i == len - 1);
        if ($urandom_range(3, 0) == 0) begin
          i_valid = 1'b0;
          repeat ($urandom_range(3, 1)) begin
            @(posedge i_clk); #1;
            i_ready = 1'($urandom_range(1, 0));
          end
        end
      end
      i_valid = 1'b0; i_last = 1'b0;
    end
    rnd_ready = 1'b0;
    i_ready = 1'b1;
    repeat (10) @(posedge i_clk);
    #1 i_ready = 1'b0;
    @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa_sum_sequencer.md
Name: csa_sum_sequencer

Overview:
- Streaming accumulator that sums a variable-length frame of unsigned operands using one shared instance of the 6-input carry-save adder, `csa_adder_6in`.
- Each adder pass combines the running partial sum with up to 5 buffered operands.
- The frame total is presented on a valid/ready output.
- Sits between spike/weight fetch logic and the neuron potential update in the ODESA datapath.

Parameters:
- P_WIDTH, 14: operand width in bits. Operands are zero-extended to P_ACC_WIDTH.
- P_ACC_WIDTH, 20: accumulator width. Sets p_input_width of the `csa_adder_6in` instance. Must be >= P_WIDTH.
- P_CNT_WIDTH, 8: operand counter width.

Ports:
- i_clk  input  1  clock. All logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  P_WIDTH  operand.
- i_valid  input  1  operand valid.
- i_last  input  1  marks the final operand of a frame. Qualified by i_valid.
- o_ready  output  1  block can accept an operand this cycle.
- o_sum  output  P_ACC_WIDTH  frame total.
- o_count  output  P_CNT_WIDTH  number of operands in the frame, modulo 2^P_CNT_WIDTH.
- o_ovf  output  1  frame total exceeded 2^P_ACC_WIDTH-1.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.

Behaviour:
- Reset values (next edge with i_rst=1, any state):
  - state=S_COLLECT; acc, slot[0..4], slot count, o_count, last flag all 0.
  - o_ready=1, o_valid=0, o_sum=0, o_ovf=0.
- Operand transfer: a transfer occurs when i_valid & o_ready. o_ready is high only in S_COLLECT.
- S_COLLECT:
  - Each transfer writes i_data into slot[n], then n++ and o_count++.
  - i_last is latched on a transfer.
  - Go to S_ADD when a transfer makes n==5 or carries i_last=1. Otherwise stay.
  - With no transfer, all state is held.
- S_ADD (exactly 1 cycle, o_ready=0):
  - Adder inputs: a=acc, b..f=slot[0..4]. Unfilled slots are 0.
  - The full-width adder output (P_ACC_WIDTH+3 bits) is registered.
  - acc <= low P_ACC_WIDTH bits. Any upper bit nonzero sets the sticky ovf flag.
  - Slots and n are cleared.
  - Next state is S_DONE if the last flag is set, otherwise S_COLLECT.
- S_DONE:
  - o_valid=1. o_sum=acc; o_count and o_ovf are the frame values. All are stable while i_ready=0.
  - On i_ready=1: go to S_COLLECT; acc, o_count, ovf and last flag are cleared; o_valid drops next cycle.
- Latency:
  - o_valid rises 2 cycles after the transfer carrying i_last.
  - A frame of N operands costs N + ceil(N/5) + 1 cycles minimum.
- Boundaries:
  - i_last on the 5th slot: one S_ADD pass, then S_DONE. No empty extra pass.
  - Zero-operand frames cannot occur, because i_last rides on an operand.
  - i_valid while o_ready=0 is not consumed; the source must hold its data.
  - o_count wraps silently.
  - Reset mid-frame discards the partial frame entirely.

Optional Feature:
- Macro: CSA_SEQ_SAT_EN.
- Defined: on overflow, acc is forced to all-ones and held there for the rest of the frame. o_sum=2^P_ACC_WIDTH-1, and o_ovf is still set.
- Undefined: acc wraps modulo 2^P_ACC_WIDTH and o_ovf is set. Saturation logic is absent.

Test Plan (defaults):
1. Operands 1, 2, 3 with i_last on the 3rd -> one S_ADD pass; o_sum=6, o_count=3, o_ovf=0; o_valid exactly 2 cycles after the 3rd transfer.
2. 12 operands of 100, i_valid held high -> o_ready low for one cycle after the 5th and 10th transfers; o_sum=1200, o_count=12.
3. Hold i_ready=0 for 5 cycles in S_DONE -> o_valid, o_sum, o_count stable and o_ready=0 throughout. A following frame {7} after the handshake -> o_sum=7.
4. 80 operands of 16383:
   - Without CSA_SEQ_SAT_EN -> o_sum=262064, o_ovf=1.
   - With CSA_SEQ_SAT_EN -> o_sum=1048575, o_ovf=1.
5. Assert i_rst for 1 cycle after 4 operands of 50 -> next cycle o_ready=1, o_valid=0. Next frame {9} -> o_sum=9, o_count=1.
6. Single operand 16383 with i_last, i_ready tied high -> o_sum=16383, o_count=1; o_valid is a 1-cycle pulse; o_ready returns high the following cycle.
